bus_master_arbiter: RTL and testbench

Fixed-priority, starvation-guarded arbiter that shares the core's single memory bus master port between three requesters: the MMU page-table walker (PTW), the data memory stage (DMEM) and instruction fetch (IMEM). Once a transaction is granted, the arbiter locks ownership until the bus completes it, then re-arbitrates. It also exports busy and ownership status. The hazard detection unit consumes these so that pipeline stalls line up with real bus occupancy.

---
 rtl/bus_master_arbiter_if.sv | 72 +++++++
 rtl/bus_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_master_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_arbiter_if.sv
// Request, bus and status signals shared by the bus master arbiter
// and its environment (requesters plus the single bus slave port).
interface bus_master_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic            ptw_req_valid;
    logic [XLEN-1:0] ptw_req_addr;
    logic [XLEN-1:0] ptw_req_wdata;
    logic            ptw_req_we;
    logic [2:0]      ptw_req_size;
    logic            ptw_req_ready;
    logic [XLEN-1:0] ptw_rsp_rdata;

    logic            dmem_req_valid;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_wdata;
    logic            dmem_req_we;
    logic [2:0]      dmem_req_size;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_rsp_rdata;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic [XLEN-1:0] imem_req_wdata;
    logic            imem_req_we;
    logic [2:0]      imem_req_size;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_rsp_rdata;

    logic            bus_req_valid;
    logic [XLEN-1:0] bus_req_addr;
    logic [XLEN-1:0] bus_req_wdata;
    logic            bus_req_we;
    logic [2:0]      bus_req_size;
    logic            bus_req_ready;
    logic [XLEN-1:0] bus_rsp_rdata;

    logic            arb_busy;
    logic [1:0]      arb_owner;

    modport master (
        input  ptw_req_valid, ptw_req_addr, ptw_req_wdata,
        input  ptw_req_we, ptw_req_size,
        output ptw_req_ready, ptw_rsp_rdata,
        input  dmem_req_valid, dmem_req_addr, dmem_req_wdata,
        input  dmem_req_we, dmem_req_size,
        output dmem_req_ready, dmem_rsp_rdata,
        input  imem_req_valid, imem_req_addr, imem_req_wdata,
        input  imem_req_we, imem_req_size,
        output imem_req_ready, imem_rsp_rdata,
        output bus_req_valid, bus_req_addr, bus_req_wdata,
        output bus_req_we, bus_req_size,
        input  bus_req_ready, bus_rsp_rdata,
        output arb_busy, arb_owner
    );

    modport slave (
        output ptw_req_valid, ptw_req_addr, ptw_req_wdata,
        output ptw_req_we, ptw_req_size,
        input  ptw_req_ready, ptw_rsp_rdata,
        output dmem_req_valid, dmem_req_addr, dmem_req_wdata,
        output dmem_req_we, dmem_req_size,
        input  dmem_req_ready, dmem_rsp_rdata,
        output imem_req_valid, imem_req_addr, imem_req_wdata,
        output imem_req_we, imem_req_size,
        input  imem_req_ready, imem_rsp_rdata,
        input  bus_req_valid, bus_req_addr, bus_req_wdata,
        input  bus_req_we, bus_req_size,
        output bus_req_ready, bus_rsp_rdata,
        input  arb_busy, arb_owner
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Fixed-priority (ptw > dmem > imem) bus arbiter with ownership lock
// until completion and a starvation guard that promotes imem.
module bus_master_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bus_master_arbiter_if.master  bif
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PTW  = 2'd1;
    localparam logic [1:0] OWN_DMEM = 2'd2;
    localparam logic [1:0] OWN_IMEM = 2'd3;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [7:0] r_starve_cnt;
    logic [7:0] w_starve_nxt;
    logic [1:0] w_winner;
    logic [1:0] w_driver;
    logic       w_any;
    logic       w_promote;

    assign w_any = bif.ptw_req_valid | bif.dmem_req_valid
                 | bif.imem_req_valid;
    assign w_promote = bif.imem_req_valid & (r_starve_cnt >= LIMIT);

    always_comb begin
        w_winner = OWN_NONE;
        if (w_promote)
            w_winner = OWN_IMEM;
        else if (bif.ptw_req_valid)
            w_winner = OWN_PTW;
        else if (bif.dmem_req_valid)
            w_winner = OWN_DMEM;
        else if (bif.imem_req_valid)
            w_winner = OWN_IMEM;
    end

    // Outputs are held quiet while reset is asserted, even with requests up.
    always_comb begin
        w_driver = OWN_NONE;
        if (reset_n)
            w_driver = (r_state == LOCKED) ? r_owner : w_winner;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_any && !bif.bus_req_ready) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_winner;
                end
            end
            LOCKED: begin
                if (bif.bus_req_ready) begin
                    w_state_nxt = IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        bif.bus_req_addr  = '0;
        bif.bus_req_wdata = '0;
        bif.bus_req_we    = 1'b0;
        bif.bus_req_size  = 3'd0;
        case (w_driver)
            OWN_PTW: begin
                bif.bus_req_addr  = bif.ptw_req_addr;
                bif.bus_req_wdata = bif.ptw_req_wdata;
                bif.bus_req_we    = bif.ptw_req_we;
                bif.bus_req_size  = bif.ptw_req_size;
            end
            OWN_DMEM: begin
                bif.bus_req_addr  = bif.dmem_req_addr;
                bif.bus_req_wdata = bif.dmem_req_wdata;
                bif.bus_req_we    = bif.dmem_req_we;
                bif.bus_req_size  = bif.dmem_req_size;
            end
            OWN_IMEM: begin
                bif.bus_req_addr  = bif.imem_req_addr;
                bif.bus_req_wdata = bif.imem_req_wdata;
                bif.bus_req_we    = bif.imem_req_we;
                bif.bus_req_size  = bif.imem_req_size;
            end
            default: ;
        endcase
    end

    assign bif.bus_req_valid  = (w_driver != OWN_NONE);
    assign bif.ptw_req_ready  = bif.bus_req_ready & (w_driver == OWN_PTW);
    assign bif.dmem_req_ready = bif.bus_req_ready & (w_driver == OWN_DMEM);
    assign bif.imem_req_ready = bif.bus_req_ready & (w_driver == OWN_IMEM);

    assign bif.ptw_rsp_rdata  = bif.ptw_req_ready  ? bif.bus_rsp_rdata : '0;
    assign bif.dmem_rsp_rdata = bif.dmem_req_ready ? bif.bus_rsp_rdata : '0;
    assign bif.imem_rsp_rdata = bif.imem_req_ready ? bif.bus_rsp_rdata : '0;

    assign bif.arb_busy  = (r_state == LOCKED);
    assign bif.arb_owner = w_driver;

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!bif.imem_req_valid || bif.imem_req_ready)
            w_starve_nxt = 8'd0;
        else if (w_driver != OWN_IMEM && r_starve_cnt != 8'hFF)
            w_starve_nxt = r_starve_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

`ifndef SYNTHESIS
    logic w_owner_valid;
    always_comb begin
        w_owner_valid = 1'b0;
        case (r_owner)
            OWN_PTW:  w_owner_valid = bif.ptw_req_valid;
            OWN_DMEM: w_owner_valid = bif.dmem_req_valid;
            OWN_IMEM: w_owner_valid = bif.imem_req_valid;
            default:  w_owner_valid = 1'b0;
        endcase
    end

    a_owner_holds: assert property (
        @(posedge clk) disable iff (!reset_n)
        (r_state == LOCKED) |-> w_owner_valid
    );
`endif
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed, table-driven bench for bus_master_arbiter: priority,
// locking, zero-wait grants, starvation promotion and async reset.
module tb_bus_master_arbiter;
    localparam logic [31:0] PTW_A  = 32'h1000_0040;
    localparam logic [31:0] DMEM_A = 32'h2000_0080;
    localparam logic [31:0] IMEM_A = 32'h3000_00C0;
    localparam logic [31:0] PTW_W  = 32'h0000_0000;
    localparam logic [31:0] DMEM_W = 32'hCAFE_F00D;
    localparam logic [31:0] IMEM_W = 32'h0000_0000;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    bus_master_arbiter_if #(.XLEN(32)) bif ();

    bus_master_arbiter #(.XLEN(32), .STARVE_LIMIT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bif     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic       d;
        logic       i;
        logic       rdy;
        logic       ev;
        logic [1:0] eo;
        logic       eb;
        logic [2:0] er;
    } vec_t;

    vec_t tv[11];

    function automatic vec_t mk(logic p, logic d, logic i, logic rdy,
                                logic ev, logic [1:0] eo, logic eb,
                                logic [2:0] er);
        vec_t v;
        v.p = p; v.d = d; v.i = i; v.rdy = rdy;
        v.ev = ev; v.eo = eo; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic p, logic d, logic i, logic rdy,
                         logic [31:0] rd);
        bif.ptw_req_valid  = p;
        bif.dmem_req_valid = d;
        bif.imem_req_valid = i;
        bif.bus_req_ready  = rdy;
        bif.bus_rsp_rdata  = rd;
    endtask

    task automatic chk_payload(string tag, logic [1:0] eo);
        logic [31:0] ea;
        logic [31:0] ew;
        logic        ewe;
        logic [2:0]  es;
        case (eo)
            2'd1:    begin ea = PTW_A;  ew = PTW_W;  ewe = 0; es = 3'd2; end
            2'd2:    begin ea = DMEM_A; ew = DMEM_W; ewe = 1; es = 3'd1; end
            2'd3:    begin ea = IMEM_A; ew = IMEM_W; ewe = 0; es = 3'd2; end
            default: begin ea = 0;      ew = 0;      ewe = 0; es = 3'd0; end
        endcase
        chk({tag, " addr"}, bif.bus_req_addr, ea);
        chk({tag, " wdata"}, bif.bus_req_wdata, ew);
        chk({tag, " we"}, 32'(bif.bus_req_we), 32'(ewe));
        chk({tag, " size"}, 32'(bif.bus_req_size), 32'(es));
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  eo;
        string       tag;
        n_chk = 0;
        n_err = 0;
        reset_n = 1'b0;
        bif.ptw_req_addr   = PTW_A;
        bif.ptw_req_wdata  = PTW_W;
        bif.ptw_req_we     = 1'b0;
        bif.ptw_req_size   = 3'd2;
        bif.dmem_req_addr  = DMEM_A;
        bif.dmem_req_wdata = DMEM_W;
        bif.dmem_req_we    = 1'b1;
        bif.dmem_req_size  = 3'd1;
        bif.imem_req_addr  = IMEM_A;
        bif.imem_req_wdata = IMEM_W;
        bif.imem_req_we    = 1'b0;
        bif.imem_req_size  = 3'd2;
        drive(0, 0, 0, 0, 32'h0);

        // all-three burst, then dmem wait with late ptw arrival
        tv[0]  = mk(1, 1, 1, 1, 1, 2'd1, 0, 3'b001);
        tv[1]  = mk(0, 1, 1, 1, 1, 2'd2, 0, 3'b010);
        tv[2]  = mk(0, 0, 1, 1, 1, 2'd3, 0, 3'b100);
        tv[3]  = mk(0, 0, 0, 1, 0, 2'd0, 0, 3'b000);
        tv[4]  = mk(0, 1, 0, 0, 1, 2'd2, 0, 3'b000);
        tv[5]  = mk(1, 1, 0, 0, 1, 2'd2, 1, 3'b000);
        tv[6]  = mk(1, 1, 0, 0, 1, 2'd2, 1, 3'b000);
        tv[7]  = mk(1, 1, 0, 0, 1, 2'd2, 1, 3'b000);
        tv[8]  = mk(1, 1, 0, 1, 1, 2'd2, 1, 3'b010);
        tv[9]  = mk(1, 0, 0, 1, 1, 2'd1, 0, 3'b001);
        tv[10] = mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000);

        #3;
        chk("reset bus_valid", 32'(bif.bus_req_valid), 0);
        chk("reset owner", 32'(bif.arb_owner), 0);
        chk("reset busy", 32'(bif.arb_busy), 0);
        chk("reset readies", 32'({bif.imem_req_ready, bif.dmem_req_ready,
                                  bif.ptw_req_ready}), 0);
        chk_payload("reset", 2'd0);
        tick();
        reset_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            rd = 32'hA500_0000 | 32'(k);
            drive(tv[k].p, tv[k].d, tv[k].i, tv[k].rdy, rd);
            #2;
            tag = $sformatf("vec%0d", k);
            chk({tag, " valid"}, 32'(bif.bus_req_valid), 32'(tv[k].ev));
            chk({tag, " owner"}, 32'(bif.arb_owner), 32'(tv[k].eo));
            chk({tag, " busy"}, 32'(bif.arb_busy), 32'(tv[k].eb));
            chk({tag, " ready"}, 32'({bif.imem_req_ready,
                 bif.dmem_req_ready, bif.ptw_req_ready}), 32'(tv[k].er));
            chk({tag, " ptw_rd"}, bif.ptw_rsp_rdata,
                tv[k].er[0] ? rd : 32'h0);
            chk({tag, " dmem_rd"}, bif.dmem_rsp_rdata,
                tv[k].er[1] ? rd : 32'h0);
            chk({tag, " imem_rd"}, bif.imem_rsp_rdata,
                tv[k].er[2] ? rd : 32'h0);
            chk_payload(tag, tv[k].eo);
            tick();
        end

        // starvation: dmem re-requests every cycle against imem
        for (int k = 0; k < 18; k++) begin
            drive(0, 1, 1, 1, 32'h5555_0000 | 32'(k));
            #2;
            eo = (k == 8 || k == 17) ? 2'd3 : 2'd2;
            tag = $sformatf("starve%0d", k);
            chk({tag, " owner"}, 32'(bif.arb_owner), 32'(eo));
            chk({tag, " imem_rdy"}, 32'(bif.imem_req_ready),
                32'(eo == 2'd3));
            tick();
        end
        drive(0, 0, 0, 0, 32'h0);
        tick();

        // zero-wait ptw at a specific address
        bif.ptw_req_addr = 32'h8000_1000;
        drive(1, 0, 0, 1, 32'hDEAD_BEEF);
        #2;
        chk("zw addr", bif.bus_req_addr, 32'h8000_1000);
        chk("zw ptw_rdy", 32'(bif.ptw_req_ready), 1);
        chk("zw ptw_rd", bif.ptw_rsp_rdata, 32'hDEAD_BEEF);
        chk("zw busy", 32'(bif.arb_busy), 0);
        tick();
        bif.ptw_req_addr = PTW_A;
        drive(0, 0, 0, 0, 32'h0);
        #2;
        chk("zw busy after", 32'(bif.arb_busy), 0);
        chk("zw owner after", 32'(bif.arb_owner), 0);
        tick();

        // reset while imem holds the bus
        drive(0, 0, 1, 0, 32'h0);
        #2;
        chk("rst imem grant", 32'(bif.arb_owner), 3);
        tick();
        drive(0, 1, 1, 0, 32'h0);
        #2;
        chk("rst locked owner", 32'(bif.arb_owner), 3);
        chk("rst locked busy", 32'(bif.arb_busy), 1);
        bif.bus_req_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst bus_valid", 32'(bif.bus_req_valid), 0);
        chk("rst owner", 32'(bif.arb_owner), 0);
        chk("rst busy", 32'(bif.arb_busy), 0);
        chk("rst imem_rdy", 32'(bif.imem_req_ready), 0);
        tick();
        reset_n = 1'b1;
        drive(0, 1, 1, 1, 32'h1234_5678);
        #2;
        chk("post rst owner", 32'(bif.arb_owner), 2);
        chk("post rst dmem_rdy", 32'(bif.dmem_req_ready), 1);
        tick();
        drive(0, 0, 1, 1, 32'h1234_5678);
        #2;
        chk("post rst imem", 32'(bif.arb_owner), 3);
        chk("post rst imem_rdy", 32'(bif.imem_req_ready), 1);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        #2;
        chk("final owner", 32'(bif.arb_owner), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
